// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (minuend - subtrahend), LSB first, one bit per clock.
// A single full-subtractor cell works against a registered borrow. Visible results only
// change in the DONE cycle, so an operation in progress never disturbs them.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   r_sr_q, r_sr_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  // Full-subtractor cell outputs for the current LSB pair
  logic               d_bit_c;
  logic               br_next_c;

  // Single full-subtractor cell on the shift-register LSBs and the borrow register
  always_comb begin
    d_bit_c   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_next_c = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sr_d  = minuend;
          b_sr_d  = subtrahend;
          br_d    = 1'b0;
          cnt_d   = '0;
          a_msb_d = minuend[WIDTH-1];
          b_msb_d = subtrahend[WIDTH-1];
        end
      end
      S_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {d_bit_c, r_sr_q[WIDTH-1:1]};
        br_d   = br_next_c;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        diff_d   = r_sr_q;
        borrow_d = br_q;
        ovf_d    = (a_msb_q != b_msb_q) && (r_sr_q[WIDTH-1] != a_msb_q);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT) || (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for the bit-serial subtractor (WIDTH=4).
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;
  localparam int LAT = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;
  int seen_done;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start and let the accept edge pass; start drops afterwards unless held
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    minuend    = a;
    subtrahend = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Count negedges after the accept edge until done is seen (bounded)
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 20);
  endtask

  // Independent reference: A-B mod 2^W, unsigned borrow, signed overflow
  task automatic check_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] e_d;
    logic             e_b;
    logic             e_o;
    int               sa;
    int               sb;
    int               sd;
    e_d = WIDTH'(a - b);
    e_b = (a < b);
    sa  = a[WIDTH-1] ? int'(a) - 16 : int'(a);
    sb  = b[WIDTH-1] ? int'(b) - 16 : int'(b);
    sd  = sa - sb;
    e_o = (sd > 7) || (sd < -8);
    check({tag, "_diff"}, 32'(difference), 32'(e_d));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e_b));
    check({tag, "_ovf"}, 32'(overflow), 32'(e_o));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(difference), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: 7 - 3
    launch(4'b0111, 4'b0011, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("t1_lat", 32'(lat), 32'(LAT));
    check("t1_diff", 32'(difference), 32'h4);
    check("t1_borrow", 32'(borrow_out), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Test 2: 0 - 1
    launch(4'b0000, 4'b0001, 1'b0);
    wait_done(lat);
    check("t2_lat", 32'(lat), 32'(LAT));
    check("t2_diff", 32'(difference), 32'hF);
    check("t2_borrow", 32'(borrow_out), 32'd1);
    check("t2_ovf", 32'(overflow), 32'd0);
    @(negedge clk);

    // A == B
    launch(4'b0101, 4'b0101, 1'b0);
    wait_done(lat);
    check("eq_diff", 32'(difference), 32'h0);
    check("eq_borrow", 32'(borrow_out), 32'd0);
    check("eq_ovf", 32'(overflow), 32'd0);
    @(negedge clk);

    // Test 3: signed overflow in both directions
    launch(4'b1000, 4'b0001, 1'b0);
    wait_done(lat);
    check("t3a_diff", 32'(difference), 32'h7);
    check("t3a_borrow", 32'(borrow_out), 32'd0);
    check("t3a_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    launch(4'b0111, 4'b1000, 1'b0);
    wait_done(lat);
    check("t3b_diff", 32'(difference), 32'hF);
    check("t3b_borrow", 32'(borrow_out), 32'd1);
    check("t3b_ovf", 32'(overflow), 32'd1);
    @(negedge clk);

    // Test 4: start with new operands mid-SHIFT is ignored; results hold afterwards
    launch(4'b0111, 4'b0011, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start      = 1'b1;
    minuend    = 4'b0000;
    subtrahend = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_prev_held", 32'(difference), 32'hF);
    wait_done(lat);
    check("t4_seen_done", 32'(done), 32'd1);
    check("t4_diff", 32'(difference), 32'h4);
    check("t4_borrow", 32'(borrow_out), 32'd0);
    check("t4_ovf", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_no_restart", 32'(busy), 32'd0);
    check("t4_hold_diff", 32'(difference), 32'h4);
    check("t4_hold_done", 32'(done), 32'd0);

    // Test 5: asynchronous reset during SHIFT cycle 2
    launch(4'b1001, 4'b0010, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_diff", 32'(difference), 32'd0);
    check("t5_borrow", 32'(borrow_out), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("t5_no_done", 32'(seen_done), 32'd0);
    launch(4'b1001, 4'b0100, 1'b0);
    wait_done(lat);
    check("t5_lat", 32'(lat), 32'(LAT));
    check("t5_diff_after", 32'(difference), 32'h5);
    check("t5_borrow_after", 32'(borrow_out), 32'd0);
    check("t5_ovf_after", 32'(overflow), 32'd1);
    @(negedge clk);

    // Test 6: exhaustive, back-to-back with start held high
    start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        minuend    = WIDTH'(a);
        subtrahend = WIDTH'(b);
        @(posedge clk);
        wait_done(lat);
        check($sformatf("ex_%0d_%0d_lat", a, b), 32'(lat), 32'(LAT));
        check_result($sformatf("ex_%0d_%0d", a, b), WIDTH'(a), WIDTH'(b));
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
